regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback sources
//  (e.g. ALU, load unit, multiplier). Each source gets a valid/ready handshake.
//  Arbitration is round-robin. The granted write is registered and driven to the
//  register file as addr/data plus a 32-bit one-hot word-line enable.
//  Sits between the execute/memory units and the register-file write port.
// PARAMETERS
//  NUM_REQ  4   number of requesters; 2..8 supported
//  DATA_W   32  write data width
//  ADDR_W   5   register address width; fixed at 5 because the one-hot is 32 lines
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               synchronous, active-high reset
//  wb_stall     in   1               1 = register-file port unavailable this cycle
//  req_valid    in   NUM_REQ         per-source write request
//  req_addr     in   NUM_REQ*ADDR_W  source i address at [i*5 +: 5]
//  req_data     in   NUM_REQ*DATA_W  source i data at [i*32 +: 32]
//  req_ready    out  NUM_REQ         one-hot grant; transfer when valid & ready
//  wr_valid     out  1               registered write strobe to the register file
//  wr_addr      out  ADDR_W          registered write address
//  wr_data      out  DATA_W          registered write data
//  wr_en_onehot out  32              decoded wr_addr, gated by wr_valid
//  drop_cnt     out  16              count of accepted writes to r0, saturating
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - wr_valid=0, wr_addr=0, wr_data=0, wr_en_onehot=0, drop_cnt=0.
//    - RR pointer=0, so requester 0 has highest priority.
//    - req_ready=0 while rst is high.
//    - Reset during a pending request: the request is neither granted nor written.
//  - Grant (combinational, same cycle):
//    - If wb_stall=0, req_ready[i]=1 for the first valid requester, searching from
//      ptr upward and wrapping modulo NUM_REQ. At most one bit is set.
//    - If wb_stall=1 or no request is valid, req_ready=0.
//  - Requester rules: a requester holds valid/addr/data stable until it sees
//    ready. A requester may drop valid without being granted; no error results.
//  - Pointer: after a grant to i, ptr <= (i+1) mod NUM_REQ.
//    - No grant means ptr holds.
//    - i = NUM_REQ-1 wraps ptr to 0.
//  - Output stage: latency is one cycle from grant to the write.
//    - Next cycle, wr_addr/wr_data <= the granted addr/data.
//    - wr_valid <= granted & (addr != 0).
//    - With no grant, wr_valid <= 0 and wr_addr/wr_data hold their last value.
//  - r0 writes: granted and consumed (ready=1) but never written.
//    - wr_valid=0 and wr_en_onehot=0 for them.
//    - drop_cnt increments, saturating at 16'hFFFF.
//  - wr_en_onehot = wr_valid ? decode(wr_addr) : 32'b0. It is purely combinational
//    from registered signals, so it is glitch-free relative to clk.
//  - Stall: while wb_stall=1 there are no grants, and next cycle wr_valid=0.
//    - A write already registered completes in the cycle it is registered.
//    - Stall blocks new grants only.
//  - Back-to-back traffic: one write per cycle is sustained. With all sources
//    valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1
//    grants.
//  - Two sources targeting the same address: no merging. Writes occur in grant
//    order, so the later grant wins in the register file.
// STRUCTURE
//  - Shared package/header: ADDR_W=5, NUM_REGS=32, and the localparam
//    ZERO_REG=5'd0.
//  - Sub-module: the existing decoder_5_32 instance produces wr_en_onehot from
//    wr_addr; the output is ANDed with wr_valid.
//  - Local logic only:
//    - RR priority search (rotate, find-first, rotate back)
//    - ptr register
//    - output register
//    - drop counter
// TESTING
//  1 rst=1 for 2 cycles with all req_valid=1
//    -> req_ready=0, wr_valid=0, wr_en_onehot=0, drop_cnt=0.
//  2 only req1 valid, addr=5'd7, data=32'hDEADBEEF
//    -> req_ready=4'b0010 this cycle.
//    -> next cycle wr_valid=1, wr_addr=7, wr_en_onehot=32'h0000_0080.
//  3 all 4 valid for 8 cycles, addrs 1..4
//    -> grants 0,1,2,3,0,1,2,3.
//    -> wr_en_onehot sequence 0x2,0x4,0x8,0x10 repeated, one cycle behind the grants.
//  4 req2 valid, addr=0
//    -> req_ready[2]=1; next cycle wr_valid=0, wr_en_onehot=0, drop_cnt=1.
//  5 wb_stall=1 for 3 cycles with req0,req3 valid
//    -> req_ready=0 throughout and wr_valid=0 from the 2nd cycle.
//    -> after release, req0 is granted first, then req3.
//  6 rst asserted while req1 valid and ptr=2
//    -> after reset ptr=0, wr_valid=0, and the next grant goes to the lowest valid
//       index.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths and constants for the register-file write-port arbiter.
package regfile_wr_arbiter_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DROP_W   = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_wr_arbiter_decoder.sv
// 5-to-32 one-hot word-line decoder for the register-file write port.
module decoder_5_32
  import regfile_wr_arbiter_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [NUM_REGS-1:0] onehot_o
);

  assign onehot_o = NUM_REGS'(1) << addr_i;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ
// writeback sources; the granted write is registered and decoded to word lines.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_valid,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REGS-1:0]       wr_en_onehot,
  output logic [DROP_W-1:0]         drop_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [PTR_W-1:0]     off;
  logic [IDX_W-1:0]     idx_sum;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 any_gnt;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [DATA_W-1:0]    gnt_data;
  logic [NUM_REGS-1:0]  dec_onehot;

  // Rotate requests so ptr sits at bit 0, find first, rotate the index back.
  always_comb begin
    valid_dbl = {req_valid, req_valid} >> ptr_q;
    valid_rot = valid_dbl[NUM_REQ-1:0];
    off       = '0;
    any_gnt   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        off     = PTR_W'(k);
        any_gnt = 1'b1;
      end
    end
    any_gnt = any_gnt & ~wb_stall & ~rst;
    idx_sum = IDX_W'(ptr_q) + IDX_W'(off);
    if (idx_sum >= IDX_W'(NUM_REQ)) begin
      idx_sum = idx_sum - IDX_W'(NUM_REQ);
    end
    gnt_idx   = idx_sum[PTR_W-1:0];
    req_ready = '0;
    if (any_gnt) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for pointer, output stage and r0 drop counter.
  always_comb begin
    ptr_d      = ptr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    drop_d     = drop_q;
    if (any_gnt) begin
      ptr_d      = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      wr_valid_d = (gnt_addr != ZERO_REG);
      wr_addr_d  = gnt_addr;
      wr_data_d  = gnt_data;
      if (gnt_addr == ZERO_REG && drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_q     <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_q     <= drop_d;
    end
  end

  decoder_5_32 u_dec (
    .addr_i   (wr_addr_q),
    .onehot_o (dec_onehot)
  );

  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign drop_cnt     = drop_q;
  assign wr_en_onehot = {NUM_REGS{wr_valid_q}} & dec_onehot;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a round-robin model and a queue
// of expected register-file writes.
module tb_regfile_wr_arbiter;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] drop;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          wb_stall;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          wr_valid;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   wr_en_onehot;
  logic [15:0]   drop_cnt;

  logic [4:0]    a_tab [N];
  logic [31:0]   d_tab [N];

  int            m_ptr;
  logic [4:0]    m_addr;
  logic [31:0]   m_data;
  logic [15:0]   m_drop;
  exp_t          exp_q [$];

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_stall     (wb_stall),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_en_onehot (wr_en_onehot),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_addr[i*5 +: 5]   = a_tab[i];
      req_data[i*32 +: 32] = d_tab[i];
    end
  endtask

  task automatic do_reset(input int cycles, input logic [N-1:0] v);
    rst       = 1'b1;
    wb_stall  = 1'b0;
    req_valid = v;
    drive_bus();
    for (int c = 0; c < cycles; c++) begin
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_onehot", wr_en_onehot, 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);
    end
    rst    = 1'b0;
    m_ptr  = 0;
    m_addr = '0;
    m_data = '0;
    m_drop = '0;
    exp_q.delete();
  endtask

  // One cycle: drive at negedge, check grant, predict the write, check it after the edge.
  task automatic step(input logic [N-1:0] v, input logic stall);
    exp_t        e;
    logic [N-1:0] g;
    logic [31:0] oh;
    int          gi;
    req_valid = v;
    wb_stall  = stall;
    drive_bus();
    #1;
    g  = '0;
    gi = -1;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        if (gi < 0 && v[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(g));
    e.v = 1'b0;
    if (gi >= 0) begin
      m_addr = a_tab[gi];
      m_data = d_tab[gi];
      if (a_tab[gi] == 5'd0) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end else begin
        e.v = 1'b1;
      end
      m_ptr = (gi + 1) % N;
    end
    e.a    = m_addr;
    e.d    = m_data;
    e.drop = m_drop;
    exp_q.push_back(e);
    @(posedge clk); #1;
    e  = exp_q.pop_front();
    oh = e.v ? (32'd1 << e.a) : 32'd0;
    chk("wr_valid", 32'(wr_valid), 32'(e.v));
    chk("wr_addr", 32'(wr_addr), 32'(e.a));
    chk("wr_data", wr_data, e.d);
    chk("wr_onehot", wr_en_onehot, oh);
    chk("drop_cnt", 32'(drop_cnt), 32'(e.drop));
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    wb_stall  = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      a_tab[i] = 5'(i + 1);
      d_tab[i] = 32'hA000_0000 + 32'(i);
    end

    // Reset with every source requesting.
    do_reset(2, 4'b1111);

    // Single source, then an idle cycle that must hold addr/data.
    a_tab[1] = 5'd7;
    d_tab[1] = 32'hDEADBEEF;
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);

    // Full load: grants rotate 0,1,2,3 twice.
    do_reset(1, 4'b0000);
    for (int i = 0; i < N; i++) begin
      a_tab[i] = 5'(i + 1);
      d_tab[i] = 32'h1000_0000 * 32'(i + 1) + 32'h55;
    end
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);

    // r0 write is consumed but dropped.
    a_tab[2] = 5'd0;
    d_tab[2] = 32'h0BAD_F00D;
    step(4'b0100, 1'b0);

    // Top word line, moves ptr back to 0.
    a_tab[3] = 5'd31;
    d_tab[3] = 32'hCAFE_0031;
    step(4'b1000, 1'b0);

    // Stall with two sources pending, then release.
    a_tab[0] = 5'd9;
    d_tab[0] = 32'h0000_0909;
    for (int c = 0; c < 3; c++) step(4'b1001, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b1000, 1'b0);

    // Same address from two sources, written in grant order.
    a_tab[1] = 5'd12;
    d_tab[1] = 32'h1111_1111;
    a_tab[2] = 5'd12;
    d_tab[2] = 32'h2222_2222;
    step(4'b0110, 1'b0);
    step(4'b0100, 1'b0);

    // Grant to req1 leaves ptr=2, then reset with req1 pending.
    a_tab[1] = 5'd3;
    d_tab[1] = 32'h3333_0003;
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    a_tab[3] = 5'd4;
    step(4'b0100, 1'b0);
    step(4'b0010, 1'b0);
    do_reset(1, 4'b0010);
    step(4'b1010, 1'b0);
    step(4'b1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
